// File: rtl/clause_eval_unit_if.sv
// Controller <-> clause-slot bundle: load, assignment broadcast, backtrack, status and implication handshake.
// The master modport is the BCP controller; the slave modport is one clause_eval_unit.
interface clause_eval_unit_if #(
  parameter int VARIABLE_ENCODING_LEN = 3,
  parameter int MAX_CLAUSE_SIZE       = 3,
  parameter int CLAUSE_ID_LEN         = 4,
  parameter int LEVEL_LEN             = 4
);
  logic                                             update_clause_i;
  logic [CLAUSE_ID_LEN-1:0]                         clause_id_to_set_i;
  logic [VARIABLE_ENCODING_LEN*MAX_CLAUSE_SIZE-1:0] set_variable_id_i;
  logic [MAX_CLAUSE_SIZE-1:0]                       set_variable_polarity_i;
  logic                                             update_assignment_i;
  logic [VARIABLE_ENCODING_LEN-1:0]                 decision_variable_id_i;
  logic                                             decision_assignment_i;
  logic [LEVEL_LEN-1:0]                             decision_level_i;
  logic                                             backtrack_i;
  logic [LEVEL_LEN-1:0]                             backtrack_level_i;
  logic                                             clause_SAT_o;
  logic                                             conflict_o;
  logic                                             unit_o;
  logic                                             implication_valid_o;
  logic                                             implication_ready_i;
  logic [VARIABLE_ENCODING_LEN-1:0]                 implication_variable_id_o;
  logic                                             implication_assignment_o;

  modport master (
    output update_clause_i, clause_id_to_set_i, set_variable_id_i, set_variable_polarity_i,
    output update_assignment_i, decision_variable_id_i, decision_assignment_i, decision_level_i,
    output backtrack_i, backtrack_level_i, implication_ready_i,
    input  clause_SAT_o, conflict_o, unit_o, implication_valid_o,
    input  implication_variable_id_o, implication_assignment_o
  );

  modport slave (
    input  update_clause_i, clause_id_to_set_i, set_variable_id_i, set_variable_polarity_i,
    input  update_assignment_i, decision_variable_id_i, decision_assignment_i, decision_level_i,
    input  backtrack_i, backtrack_level_i, implication_ready_i,
    output clause_SAT_o, conflict_o, unit_o, implication_valid_o,
    output implication_variable_id_o, implication_assignment_o
  );
endinterface

// File: rtl/clause_eval_unit.sv
// One clause slot of the BCP accelerator: literal state, SAT/conflict/unit status and a unit-implication offer.
// Define CLAUSE_LEVEL_TRACK_EN for per-literal decision levels and selective backtrack; otherwise backtrack clears the clause.
module clause_eval_unit #(
  parameter int MAX_VARIABLE_ID       = 4,
  parameter int VARIABLE_ENCODING_LEN = $clog2(MAX_VARIABLE_ID + 1),
  parameter int MAX_CLAUSE_SIZE       = 3,
  parameter int MAX_CLAUSE            = 16,
  parameter int CLAUSE_ID             = 0,
  parameter int CLAUSE_ID_LEN         = $clog2(MAX_CLAUSE),
  parameter int MAX_LEVEL             = 15,
  parameter int LEVEL_LEN             = $clog2(MAX_LEVEL + 1)
) (
  input logic               clk_i,
  input logic               rst_i,
  clause_eval_unit_if.slave bus
);
  localparam int VEL     = VARIABLE_ENCODING_LEN;
  localparam int CNT_LEN = $clog2(MAX_CLAUSE_SIZE + 1);

  typedef enum logic [1:0] {EMPTY, EVAL, OFFER, SENT} hs_state_t;

  logic [VEL-1:0]             ids [MAX_CLAUSE_SIZE];
  logic [MAX_CLAUSE_SIZE-1:0] pol;
  logic [1:0]                 asg [MAX_CLAUSE_SIZE];
  logic                       in_use;
  hs_state_t                  state;
  hs_state_t                  state_next;

  logic                       load_hit;
  logic                       do_backtrack;
  logic                       do_assign;
  logic                       assign_changed;
  logic [MAX_CLAUSE_SIZE-1:0] used;
  logic [MAX_CLAUSE_SIZE-1:0] lit_true;
  logic [MAX_CLAUSE_SIZE-1:0] unassigned;
  logic [MAX_CLAUSE_SIZE-1:0] hit;
  logic [CNT_LEN-1:0]         n_unassigned;
  logic [VEL-1:0]             open_id;
  logic                       open_pol;
  logic                       sat;
  logic                       conflict;
  logic                       unit;
  logic                       valid;

  // Same-cycle priority: reset, load, backtrack, assignment; the loser is dropped.
  assign load_hit       = bus.update_clause_i && (bus.clause_id_to_set_i == CLAUSE_ID_LEN'(CLAUSE_ID));
  assign do_backtrack   = bus.backtrack_i && !load_hit;
  assign do_assign      = bus.update_assignment_i && !bus.backtrack_i && !load_hit;
  assign assign_changed = do_assign && (|hit);

  always_comb begin
    used       = '0;
    lit_true   = '0;
    unassigned = '0;
    hit        = '0;
    for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
      used[k]       = (ids[k] != '0);
      lit_true[k]   = used[k] && asg[k][1] && (asg[k][0] == pol[k]);
      unassigned[k] = used[k] && !asg[k][1];
      hit[k]        = unassigned[k] && (ids[k] == bus.decision_variable_id_i);
    end
  end

  // Unused slots never count as open, so they behave as assigned-false literals.
  always_comb begin
    n_unassigned = '0;
    open_id      = '0;
    open_pol     = 1'b0;
    for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
      if (unassigned[k]) begin
        n_unassigned = n_unassigned + CNT_LEN'(1);
        open_id      = ids[k];
        open_pol     = pol[k];
      end
    end
  end

  assign sat      = !in_use || (|lit_true);
  assign conflict = in_use && !(|lit_true) && (n_unassigned == '0);
  assign unit     = in_use && !(|lit_true) && (n_unassigned == CNT_LEN'(1));

`ifdef CLAUSE_LEVEL_TRACK_EN
  logic [LEVEL_LEN-1:0] lvl [MAX_CLAUSE_SIZE];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < MAX_CLAUSE_SIZE; k++) lvl[k] <= '0;
    end else if (do_assign) begin
      for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
        if (hit[k]) lvl[k] <= bus.decision_level_i;
      end
    end
  end
`else
  logic unused_levels;
  assign unused_levels = ^{bus.decision_level_i, bus.backtrack_level_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_use <= 1'b0;
      pol    <= '0;
      for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
        ids[k] <= '0;
        asg[k] <= '0;
      end
    end else if (load_hit) begin
      in_use <= 1'b1;
      pol    <= bus.set_variable_polarity_i;
      for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
        ids[k] <= bus.set_variable_id_i[k*VEL +: VEL];
        asg[k] <= '0;
      end
    end else if (do_backtrack) begin
      for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
`ifdef CLAUSE_LEVEL_TRACK_EN
        if (lvl[k] > bus.backtrack_level_i) asg[k] <= '0;
`else
        asg[k] <= '0;
`endif
      end
    end else if (do_assign) begin
      // An already-assigned literal keeps its value until a backtrack.
      for (int k = 0; k < MAX_CLAUSE_SIZE; k++) begin
        if (hit[k]) asg[k] <= {1'b1, bus.decision_assignment_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_next;
  end

  // SENT holds off a repeat offer until the clause changes under it.
  always_comb begin
    state_next = state;
    if (load_hit) begin
      state_next = EVAL;
    end else begin
      case (state)
        EMPTY: state_next = state;
        EVAL:  if (unit) state_next = OFFER;
        OFFER: begin
          if (!unit)                        state_next = EVAL;
          else if (bus.implication_ready_i) state_next = SENT;
        end
        SENT:  if (do_backtrack || assign_changed) state_next = EVAL;
        default: state_next = EMPTY;
      endcase
    end
    valid = (state == OFFER) && unit;
  end

  assign bus.clause_SAT_o              = sat;
  assign bus.conflict_o                = conflict;
  assign bus.unit_o                    = unit;
  assign bus.implication_valid_o       = valid;
  assign bus.implication_variable_id_o = unit ? open_id : '0;
  assign bus.implication_assignment_o  = unit && open_pol;
endmodule
